// File: rtl/commit_trace_checker.sv
// commit_trace_checker: buffers CPU commit events in a FIFO and compares each one against a streamed golden trace record.
// Ports:
//   clk, reset (async, active-low), enable (start, sampled in IDLE)
//   commit_* : retire stream from the CPU; commit_stall asks the CPU to hold
//   exp_*    : golden record stream (valid/ready); exp_last marks the final record
//   done/pass/fail, err_index, err_field {wr,inst,pc}, match_count : latched results
module commit_trace_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic             commit_we,
  input  logic [4:0]       commit_waddr,
  input  logic [31:0]      commit_wdata,
  output logic             commit_stall,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_pc,
  input  logic [31:0]      exp_inst,
  input  logic             exp_we,
  input  logic [4:0]       exp_waddr,
  input  logic [31:0]      exp_wdata,
  input  logic             exp_last,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_index,
  output logic [2:0]       err_field,
  output logic [CNT_W-1:0] match_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 102;
  typedef enum logic [1:0] {IDLE, RUN, PASSED, FAILED} state_t;
  state_t state, state_d;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          run, full, push, pop, err;
  logic [31:0]   h_pc, h_inst, h_wdata;
  logic [4:0]    h_waddr;
  logic          h_we_raw, h_we, e_we;
  logic [2:0]    field;
  assign run          = state == RUN;
  assign full         = count == (AW+1)'(DEPTH);
  assign commit_stall = run && full;
  assign push         = run && commit_valid && !full;
  assign pop          = run && count != '0 && exp_valid;
  assign exp_ready    = pop;
  assign {h_pc, h_inst, h_we_raw, h_waddr, h_wdata} = mem[rd_ptr];
  // writes to r0 are architecturally invisible, so they count as no write
  assign h_we  = h_we_raw && h_waddr != '0;
  assign e_we  = exp_we && exp_waddr != '0;
  assign field = {(h_we != e_we) || (h_we && e_we && (h_waddr != exp_waddr || h_wdata != exp_wdata)),
                  h_inst != exp_inst,
                  h_pc != exp_pc};
  assign err   = |field;
  assign pass  = state == PASSED;
  assign fail  = state == FAILED;
  assign done  = pass || fail;
  always_comb begin
    state_d = state;
    if (state == IDLE && enable) state_d = RUN;
    else if (pop) state_d = err ? FAILED : exp_last ? PASSED : RUN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {commit_pc, commit_inst, commit_we, commit_waddr, commit_wdata};
  end
  // outside RUN the FIFO is held empty, which also flushes it on entering PASS/FAIL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= run ? wr_ptr + AW'(push) : '0;
      rd_ptr <= run ? rd_ptr + AW'(pop) : '0;
      count  <= run ? count + (AW+1)'(push) - (AW+1)'(pop) : '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      err_index   <= '0;
      err_field   <= '0;
    end else if (pop && err) begin
      err_index <= match_count;
      err_field <= field;
    end else if (pop && !(&match_count)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
endmodule
